// File: rtl/asynch_edge_detect_multi.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : asynch_edge_detect_multi
//  Description : Multi-channel asynchronous edge detector. Each channel
//                synchronises an asynchronous pin into SYNC_CLK_IN. It then
//                glitch-filters the synchronised level with a stability
//                counter and qualifies rising/falling/both edges. Every
//                qualified edge is reported as a one-cycle pulse, a sticky
//                flag and an overrun flag.
//
//  Ports       :
//    SYNC_CLK_IN     in   1         sole clock, rising edge
//    RESET_N_IN      in   1         synchronous active-low reset
//    ASYNC_IN        in   NUM_CH    asynchronous inputs
//    EDGE_MODE_IN    in   2*NUM_CH  per channel: 00 off, 01 rise, 10 fall, 11 both
//    CLEAR_IN        in   NUM_CH    per-channel clear of sticky/overrun
//    READY_OUT       out  1         initialisation complete, outputs valid
//    LEVEL_OUT       out  NUM_CH    filtered synchronised level
//    EDGE_PULSE_OUT  out  NUM_CH    one-cycle pulse per qualified edge
//    STICKY_OUT      out  NUM_CH    latched qualified-edge flag
//    OVERRUN_OUT     out  NUM_CH    edge seen while sticky set and not cleared
//
//  Revision    : 1.0  initial release
// ============================================================================
module asynch_edge_detect_multi #(
  parameter int NUM_CH        = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4
) (
  input  logic                  SYNC_CLK_IN,
  input  logic                  RESET_N_IN,
  input  logic [NUM_CH-1:0]     ASYNC_IN,
  input  logic [2*NUM_CH-1:0]   EDGE_MODE_IN,
  input  logic [NUM_CH-1:0]     CLEAR_IN,
  output logic                  READY_OUT,
  output logic [NUM_CH-1:0]     LEVEL_OUT,
  output logic [NUM_CH-1:0]     EDGE_PULSE_OUT,
  output logic [NUM_CH-1:0]     STICKY_OUT,
  output logic [NUM_CH-1:0]     OVERRUN_OUT
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int c_cnt_w  = $clog2(FILTER_CYCLES + 1);
  localparam int c_init_w = $clog2(SYNC_STAGES + 1);

  // Final INIT edge: the synchroniser has been filled with real samples.
  localparam logic [c_init_w-1:0] c_init_last = c_init_w'(SYNC_STAGES);
  // Counter value on the edge where a new level is accepted.
  localparam logic [c_cnt_w-1:0]  c_cnt_last  = c_cnt_w'(FILTER_CYCLES - 1);
  localparam logic [c_cnt_w-1:0]  c_cnt_one   = c_cnt_w'(1);

  // --------------------------------------------------------------------------
  // Global INIT -> RUN state machine
  // --------------------------------------------------------------------------
  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              r_state;
  logic [c_init_w-1:0] r_init_cnt;
  logic                r_ready;

  always_ff @(posedge SYNC_CLK_IN) begin
    if (!RESET_N_IN) begin
      r_state    <= ST_INIT;
      r_init_cnt <= '0;
      r_ready    <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          if (r_init_cnt == c_init_last) begin
            r_state    <= ST_RUN;
            r_init_cnt <= '0;
            r_ready    <= 1'b1;
          end else begin
            r_init_cnt <= r_init_cnt + c_init_w'(1);
          end
        end
        ST_RUN: begin
          r_ready <= 1'b1;
        end
        default: begin
          r_state    <= ST_INIT;
          r_init_cnt <= '0;
          r_ready    <= 1'b0;
        end
      endcase
    end
  end

  // The channel filters take their starting level from the synchroniser on
  // the last INIT edge, so no edge is ever reported for the initial state.
  logic w_load;
  logic w_run;

  assign w_load    = (r_state == ST_INIT) && (r_init_cnt == c_init_last);
  assign w_run     = (r_state == ST_RUN);
  assign READY_OUT = r_ready;

  // --------------------------------------------------------------------------
  // Per-channel synchroniser, glitch filter and edge reporting
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_level;
    logic                   r_counting;
    logic [c_cnt_w-1:0]     r_cnt;
    logic                   r_pulse;
    logic                   r_sticky;
    logic                   r_overrun;

    logic                   w_s;
    logic [1:0]             w_mode;
    logic                   w_edge;
    logic                   w_qual;

    assign w_s    = r_sync[SYNC_STAGES-1];
    assign w_mode = EDGE_MODE_IN[2*i +: 2];

    // A level change is accepted either on the first differing sample (single
    // sample filter) or when the run of differing samples reaches the limit.
    always_comb begin
      w_edge = 1'b0;
      if (w_run && (w_s != r_level)) begin
        if (FILTER_CYCLES == 1) begin
          w_edge = 1'b1;
        end else if (r_counting && (r_cnt == c_cnt_last)) begin
          w_edge = 1'b1;
        end
      end
    end

    // The mode is looked at combinationally on the edge cycle, and the
    // direction is judged from the level being accepted (w_s).
    always_comb begin
      w_qual = 1'b0;
      if (w_edge) begin
        case (w_mode)
          2'b01:   w_qual = w_s;
          2'b10:   w_qual = ~w_s;
          2'b11:   w_qual = 1'b1;
          default: w_qual = 1'b0;
        endcase
      end
    end

    always_ff @(posedge SYNC_CLK_IN) begin
      if (!RESET_N_IN) begin
        r_sync     <= '0;
        r_level    <= 1'b0;
        r_counting <= 1'b0;
        r_cnt      <= '0;
        r_pulse    <= 1'b0;
        r_sticky   <= 1'b0;
        r_overrun  <= 1'b0;
      end else begin
        r_sync  <= {r_sync[SYNC_STAGES-2:0], ASYNC_IN[i]};
        r_pulse <= w_qual;

        if (w_load) begin
          r_level    <= w_s;
          r_counting <= 1'b0;
          r_cnt      <= '0;
        end else if (w_run) begin
          if (w_edge) begin
            r_level    <= w_s;
            r_counting <= 1'b0;
            r_cnt      <= '0;
          end else if (w_s == r_level) begin
            // Stable, or a glitch shorter than the filter: drop the count.
            r_counting <= 1'b0;
            r_cnt      <= '0;
          end else if (!r_counting) begin
            r_counting <= 1'b1;
            r_cnt      <= c_cnt_one;
          end else begin
            r_cnt      <= r_cnt + c_cnt_one;
          end

          // Set wins over clear so an edge arriving with a clear is not lost.
          if (w_qual) begin
            r_sticky <= 1'b1;
          end else if (CLEAR_IN[i]) begin
            r_sticky <= 1'b0;
          end

          // A clear acknowledges the previous event, so an edge coinciding
          // with it is not an overrun.
          if (CLEAR_IN[i]) begin
            r_overrun <= 1'b0;
          end else if (w_qual && r_sticky) begin
            r_overrun <= 1'b1;
          end
        end
      end
    end

    assign LEVEL_OUT[i]      = r_level;
    assign EDGE_PULSE_OUT[i] = r_pulse;
    assign STICKY_OUT[i]     = r_sticky;
    assign OVERRUN_OUT[i]    = r_overrun;
  end

endmodule
`default_nettype wire

// File: tb/tb_asynch_edge_detect_multi.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_asynch_edge_detect_multi
//  Description : Directed self-checking bench for asynch_edge_detect_multi
//                at default parameters (4 channels, 2 sync stages, filter 4).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_asynch_edge_detect_multi;

  logic       clk;
  logic       rst_n;
  logic [3:0] async_in;
  logic [7:0] edge_mode;
  logic [3:0] clear_in;
  logic       ready;
  logic [3:0] level;
  logic [3:0] pulse;
  logic [3:0] sticky;
  logic [3:0] overrun;

  int n_cmp;
  int n_err;
  logic [3:0] lvl_prev;

  asynch_edge_detect_multi #(
    .NUM_CH        (4),
    .SYNC_STAGES   (2),
    .FILTER_CYCLES (4)
  ) u_dut (
    .SYNC_CLK_IN    (clk),
    .RESET_N_IN     (rst_n),
    .ASYNC_IN       (async_in),
    .EDGE_MODE_IN   (edge_mode),
    .CLEAR_IN       (clear_in),
    .READY_OUT      (ready),
    .LEVEL_OUT      (level),
    .EDGE_PULSE_OUT (pulse),
    .STICKY_OUT     (sticky),
    .OVERRUN_OUT    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Advance n rising edges; sampling and driving happen 1ns after the edge.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present a new input pattern before edge k. The new level must appear,
  // with the given pulse, exactly after edge k+5, and not before.
  task automatic run_edge(input logic [3:0] a, input logic [3:0] exp_pulse,
                          input logic [3:0] clr_on_edge);
    async_in = a;
    for (int k = 0; k < 5; k++) begin
      tick(1);
      check_eq("hold_level", level, lvl_prev);
      check_eq("hold_pulse", pulse, 4'b0000);
    end
    clear_in = clr_on_edge;
    tick(1);
    clear_in = 4'b0000;
    check_eq("edge_level", level, a);
    check_eq("edge_pulse", pulse, exp_pulse);
    lvl_prev = a;
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    async_in  = 4'b0101;
    edge_mode = 8'h00;
    clear_in  = 4'b0000;
    lvl_prev  = 4'b0000;

    // 1: reset and initialisation
    tick(2);
    check_eq("rst_ready",   {3'b000, ready}, 4'b0000);
    check_eq("rst_level",   level,   4'b0000);
    check_eq("rst_pulse",   pulse,   4'b0000);
    check_eq("rst_sticky",  sticky,  4'b0000);
    check_eq("rst_overrun", overrun, 4'b0000);
    rst_n = 1'b1;
    tick(1);
    check_eq("init1_ready", {3'b000, ready}, 4'b0000);
    tick(1);
    check_eq("init2_ready", {3'b000, ready}, 4'b0000);
    tick(1);
    check_eq("init3_ready", {3'b000, ready}, 4'b0001);
    check_eq("init3_level", level,  4'b0101);
    check_eq("init3_pulse", pulse,  4'b0000);
    check_eq("init3_sticky", sticky, 4'b0000);
    lvl_prev = 4'b0101;

    // 2: ch0 rising edge in mode 01 (first drop it with mode off)
    run_edge(4'b0100, 4'b0000, 4'b0000);
    edge_mode = 8'b0000_0001;
    run_edge(4'b0101, 4'b0001, 4'b0000);
    check_eq("t2_sticky", sticky, 4'b0001);
    check_eq("t2_overrun", overrun, 4'b0000);
    tick(1);
    check_eq("t2_pulse_one_cycle", pulse, 4'b0000);

    // 3: ch1 glitch of 3 samples rejected, 4 samples accepted
    edge_mode = 8'b0000_1101;
    async_in  = 4'b0111;
    tick(3);
    async_in  = 4'b0101;
    for (int k = 0; k < 8; k++) begin
      tick(1);
      check_eq("glitch_level", level, 4'b0101);
      check_eq("glitch_pulse", pulse, 4'b0000);
    end
    async_in = 4'b0111;
    for (int k = 0; k < 4; k++) begin
      tick(1);
      check_eq("w4_pre_level", level, 4'b0101);
    end
    async_in = 4'b0101;
    tick(1);
    check_eq("w4_k4_level", level, 4'b0101);
    tick(1);
    check_eq("w4_rise_level", level, 4'b0111);
    check_eq("w4_rise_pulse", pulse, 4'b0010);
    check_eq("w4_rise_sticky", sticky, 4'b0011);
    for (int k = 0; k < 3; k++) begin
      tick(1);
      check_eq("w4_high_level", level, 4'b0111);
      check_eq("w4_high_pulse", pulse, 4'b0000);
    end
    tick(1);
    check_eq("w4_fall_level", level, 4'b0101);
    check_eq("w4_fall_pulse", pulse, 4'b0010);
    check_eq("w4_fall_sticky", sticky, 4'b0011);
    check_eq("w4_fall_overrun", overrun, 4'b0010);
    clear_in = 4'b1111;
    tick(1);
    clear_in = 4'b0000;
    check_eq("clr_sticky", sticky, 4'b0000);
    check_eq("clr_overrun", overrun, 4'b0000);
    lvl_prev = 4'b0101;

    // 4: ch2 mode 10 and mode 00
    run_edge(4'b0001, 4'b0000, 4'b0000);
    edge_mode = 8'b0010_1101;
    run_edge(4'b0101, 4'b0000, 4'b0000);
    run_edge(4'b0001, 4'b0100, 4'b0000);
    check_eq("t4_sticky", sticky, 4'b0100);
    edge_mode = 8'b0000_1101;
    run_edge(4'b0101, 4'b0000, 4'b0000);
    check_eq("t4_sticky_kept", sticky, 4'b0100);

    // 5: ch3 mode 11, overrun and clear interactions
    clear_in = 4'b1111;
    tick(1);
    clear_in = 4'b0000;
    check_eq("t5_clr_sticky", sticky, 4'b0000);
    edge_mode = 8'b1100_1101;
    run_edge(4'b1101, 4'b1000, 4'b0000);
    check_eq("t5_e1_sticky", sticky, 4'b1000);
    check_eq("t5_e1_overrun", overrun, 4'b0000);
    run_edge(4'b0101, 4'b1000, 4'b0000);
    check_eq("t5_e2_sticky", sticky, 4'b1000);
    check_eq("t5_e2_overrun", overrun, 4'b1000);
    clear_in = 4'b1000;
    tick(1);
    clear_in = 4'b0000;
    check_eq("t5_clr3_sticky", sticky, 4'b0000);
    check_eq("t5_clr3_overrun", overrun, 4'b0000);
    run_edge(4'b1101, 4'b1000, 4'b0000);
    check_eq("t5_e3_sticky", sticky, 4'b1000);
    run_edge(4'b0101, 4'b1000, 4'b1000);
    check_eq("t5_coinc_sticky", sticky, 4'b1000);
    check_eq("t5_coinc_overrun", overrun, 4'b0000);

    // 6: reset while ch0 is counting
    edge_mode = 8'hFF;
    async_in  = 4'b0100;
    tick(3);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    check_eq("t6_rst_ready",   {3'b000, ready}, 4'b0000);
    check_eq("t6_rst_level",   level,   4'b0000);
    check_eq("t6_rst_pulse",   pulse,   4'b0000);
    check_eq("t6_rst_sticky",  sticky,  4'b0000);
    check_eq("t6_rst_overrun", overrun, 4'b0000);
    tick(2);
    check_eq("t6_init_ready", {3'b000, ready}, 4'b0000);
    tick(1);
    check_eq("t6_ready", {3'b000, ready}, 4'b0001);
    check_eq("t6_level", level, 4'b0100);
    check_eq("t6_pulse", pulse, 4'b0000);
    for (int k = 0; k < 6; k++) begin
      tick(1);
      check_eq("t6_quiet_pulse", pulse, 4'b0000);
      check_eq("t6_quiet_level", level, 4'b0100);
      check_eq("t6_quiet_sticky", sticky, 4'b0000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
